scmp_acc_sr: RTL and testbench
==============================

Name: scmp_acc_sr

Overview:
- Register stage directly downstream of the SC/MP ALU.
- Holds the accumulator (AC), the extension register (E) and the status register (SR).
- Latches the ALU result and the CY/OV flags, and feeds AC, CY and OV back as the ALU A operand, Cy_i and Ov_i.
- Also implements the E-register serial shift (SIO), the accumulator exchange (XAE) and the DLY microcycle delay counter.

Parameters:
- DLY_BASE, 13, fixed microcycle overhead of DLY.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ce  in  1  microcycle enable; all state changes are qualified by ce
- alu_res  in  8  ALU result
- alu_cy  in  1  ALU carry out
- alu_ov  in  1  ALU overflow out
- ac_we  in  1  AC <= alu_res
- e_we  in  1  E <= alu_res
- flag_we  in  1  SR[7] <= alu_cy; SR[6] <= alu_ov
- xae  in  1  swap AC and E
- sr_we  in  1  CAS: SR writable bits <= AC
- ie_set  in  1  SR[3] <= 1
- ie_clr  in  1  SR[3] <= 0
- sio_en  in  1  shift E right one place
- sin  in  1  serial input, shifted into E[7]
- sout  out  1  serial output, equal to E[0] (combinational)
- sense_a  in  1  sense A pin, drives SR[4]
- sense_b  in  1  sense B pin, drives SR[5]
- dly_start  in  1  start DLY
- dly_disp  in  8  DLY displacement
- dly_busy  out  1  DLY in progress
- dly_done  out  1  one-clk pulse at DLY completion
- ac_o  out  8  AC to ALU A / bus
- e_o  out  8  E
- sr_o  out  8  {CY, OV, SB, SA, IE, F2, F1, F0}
- cy_o  out  1  SR[7], to ALU Cy_i
- ov_o  out  1  SR[6], to ALU Ov_i
- f_o  out  3  SR[2:0], flag output pins

Behaviour:
- Reset (async, rst_n low):
  - AC, E, SR[7:6] and SR[3:0] go to 0.
  - dly_busy and dly_done go to 0; DLY counter goes to 0.
  - Applies immediately and aborts any DLY in progress; AC stays 0 after the abort.
- SR[5:4] are not stored: sr_o[5:4] = {sense_b, sense_a}, read-only.
- All updates occur on a clk edge with ce=1. With ce=0 all state holds, dly_done is 0, and the DLY count does not advance.
- Priority, per register:
  - AC: xae > ac_we.
  - E: xae > e_we > sio_en.
  - SR[7:6]: flag_we > sr_we.
  - SR[3]: ie_clr > ie_set > sr_we.
  - SR[2:0]: written by sr_we only.
- xae: AC <= old E and E <= old AC, in the same edge.
- sio_en: E <= {sin, E[7:1]}. sout always equals the current E[0].
- sr_we: SR[7:6] <= AC[7:6], SR[3:0] <= AC[3:0]; AC[5:4] are ignored.
- DLY length: N = DLY_BASE + 2*AC + 2*dly_disp + 512*dly_disp, evaluated as an unsigned 18-bit value. Maximum N is 131593.
- DLY states:
  - IDLE:
    - On ce & dly_start: load cnt <= N and go to BUSY.
  - BUSY (dly_busy=1):
    - Each ce: cnt <= cnt-1.
    - On ce with cnt==1: AC <= 8'hFF, dly_done <= 1 for one clk, go to IDLE.
    - dly_busy is therefore high for exactly N ce-qualified cycles.
    - While BUSY, ac_we, e_we, xae, sr_we, flag_we, sio_en and dly_start are ignored; ie_set and ie_clr are still honoured.
- dly_start while idle, asserted together with other strobes: the other strobes apply in the same edge, and N uses the old AC value.

Optional Feature:
- Macro: SCMP_SENSE_SYNC_EN.
- Defined: sense_a and sense_b each pass through a two-flop synchroniser clocked every clk (not ce-gated) and reset to 0. sr_o[5:4] shows the synchronised values, 2 clk latency.
- Undefined: sr_o[5:4] are driven combinationally from the pins.

Test Plan:
- Reset while sense_a=1, sense_b=0 -> ac_o=00, e_o=00, sr_o=8'h10, dly_busy=0, sout=0.
- ac_we+flag_we with alu_res=5A, alu_cy=1, alu_ov=0 -> ac_o=5A, sr_o[7:6]=2'b10, cy_o=1. Then with ce=0 and the same strobes and different alu_res -> no change.
- AC=12, E=34, then xae with ac_we=1 -> ac_o=34, e_o=12. Then sr_we with AC=FF -> sr_o=8'hCF with sense pins low.
- E=00, sio_en for 8 ce cycles with sin=1 -> e_o=FF; sout reads 0 for the first 7 cycles, then 1.
- AC=00, disp=00, dly_start -> dly_busy high for 13 ce cycles, then dly_done pulse and ac_o=FF. AC=02, disp=01 -> busy for 531 ce cycles.
- DLY started with AC=02, disp=01; rst_n low at ce-cycle 100 -> busy=0 immediately and ac_o=00; after release no dly_done pulse occurs.

Source files
------------

// File: rtl/scmp_acc_sr.sv
// ============================================================================
// Module   : scmp_acc_sr
// Purpose  : SC/MP accumulator, extension and status registers, plus DLY timer.
// Options  : SCMP_SENSE_SYNC_EN adds a two-flop synchroniser on sense_a/sense_b.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scmp_acc_sr #(
  parameter int unsigned DLY_BASE = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic [7:0] alu_res,
  input  logic       alu_cy,
  input  logic       alu_ov,
  input  logic       ac_we,
  input  logic       e_we,
  input  logic       flag_we,
  input  logic       xae,
  input  logic       sr_we,
  input  logic       ie_set,
  input  logic       ie_clr,
  input  logic       sio_en,
  input  logic       sin,
  output logic       sout,
  input  logic       sense_a,
  input  logic       sense_b,
  input  logic       dly_start,
  input  logic [7:0] dly_disp,
  output logic       dly_busy,
  output logic       dly_done,
  output logic [7:0] ac_o,
  output logic [7:0] e_o,
  output logic [7:0] sr_o,
  output logic       cy_o,
  output logic       ov_o,
  output logic [2:0] f_o
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]  r_state;
  logic [17:0] r_cnt;
  logic        r_done;
  logic [7:0]  r_ac;
  logic [7:0]  r_e;
  logic        r_cy;
  logic        r_ov;
  logic        r_ie;
  logic [2:0]  r_f;
  logic [1:0]  w_sense;

  logic        w_busy;
  logic        w_act;
  logic        w_finish;
  logic [17:0] w_dly_n;

  assign w_busy   = (r_state == S_BUSY);
  assign w_act    = ce & ~w_busy;
  assign w_finish = ce & w_busy & (r_cnt == 18'd1);

  // N = base + 2*AC + 2*disp + 512*disp, all in 18 unsigned bits
  assign w_dly_n = 18'(DLY_BASE) + {9'd0, r_ac, 1'b0} + {9'd0, dly_disp, 1'b0}
                 + {1'b0, dly_disp, 9'd0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 18'd0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (ce) begin
        case (r_state)
          S_IDLE: begin
            if (dly_start) begin
              r_cnt   <= w_dly_n;
              r_state <= S_BUSY;
            end
          end
          default: begin
            r_cnt <= r_cnt - 18'd1;
            if (r_cnt == 18'd1) r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ac <= 8'h00;
      r_e  <= 8'h00;
    end else if (w_finish) begin
      r_ac <= 8'hFF;
    end else if (w_act) begin
      if (xae) begin
        r_ac <= r_e;
        r_e  <= r_ac;
      end else begin
        if (ac_we) r_ac <= alu_res;
        if (e_we)        r_e <= alu_res;
        else if (sio_en) r_e <= {sin, r_e[7:1]};
      end
    end
  end

  // Interrupt enable stays controllable while a DLY is running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cy <= 1'b0;
      r_ov <= 1'b0;
      r_ie <= 1'b0;
      r_f  <= 3'd0;
    end else if (ce) begin
      if (w_act) begin
        if (flag_we) begin
          r_cy <= alu_cy;
          r_ov <= alu_ov;
        end else if (sr_we) begin
          r_cy <= r_ac[7];
          r_ov <= r_ac[6];
        end
        if (sr_we) r_f <= r_ac[2:0];
      end
      if (ie_clr)                r_ie <= 1'b0;
      else if (ie_set)           r_ie <= 1'b1;
      else if (w_act && sr_we)   r_ie <= r_ac[3];
    end
  end

`ifdef SCMP_SENSE_SYNC_EN
  logic [1:0] r_sense_meta;
  logic [1:0] r_sense_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sense_meta <= 2'b00;
      r_sense_sync <= 2'b00;
    end else begin
      r_sense_meta <= {sense_b, sense_a};
      r_sense_sync <= r_sense_meta;
    end
  end

  assign w_sense = r_sense_sync;
`else
  assign w_sense = {sense_b, sense_a};
`endif

  assign sout     = r_e[0];
  assign dly_busy = w_busy;
  assign dly_done = r_done;
  assign ac_o     = r_ac;
  assign e_o      = r_e;
  assign sr_o     = {r_cy, r_ov, w_sense, r_ie, r_f};
  assign cy_o     = r_cy;
  assign ov_o     = r_ov;
  assign f_o      = r_f;

endmodule

`default_nettype wire

// File: tb/tb_scmp_acc_sr.sv
// ============================================================================
// Module   : tb_scmp_acc_sr
// Purpose  : Self-checking bench for scmp_acc_sr (default build, no sense sync).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scmp_acc_sr;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce = 1'b0;
  logic [7:0] alu_res = 8'h00;
  logic       alu_cy = 1'b0, alu_ov = 1'b0;
  logic       ac_we = 1'b0, e_we = 1'b0, flag_we = 1'b0, xae = 1'b0, sr_we = 1'b0;
  logic       ie_set = 1'b0, ie_clr = 1'b0, sio_en = 1'b0, sin = 1'b0;
  logic       sense_a = 1'b0, sense_b = 1'b0;
  logic       dly_start = 1'b0;
  logic [7:0] dly_disp = 8'h00;
  logic       sout, dly_busy, dly_done, cy_o, ov_o;
  logic [7:0] ac_o, e_o, sr_o;
  logic [2:0] f_o;

  int n_cmp = 0;
  int n_bad = 0;

  scmp_acc_sr #(.DLY_BASE(13)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .alu_res(alu_res), .alu_cy(alu_cy),
    .alu_ov(alu_ov), .ac_we(ac_we), .e_we(e_we), .flag_we(flag_we), .xae(xae),
    .sr_we(sr_we), .ie_set(ie_set), .ie_clr(ie_clr), .sio_en(sio_en), .sin(sin),
    .sout(sout), .sense_a(sense_a), .sense_b(sense_b), .dly_start(dly_start),
    .dly_disp(dly_disp), .dly_busy(dly_busy), .dly_done(dly_done), .ac_o(ac_o),
    .e_o(e_o), .sr_o(sr_o), .cy_o(cy_o), .ov_o(ov_o), .f_o(f_o)
  );

  always #5 clk = ~clk;

  // Reference model: architectural registers plus remaining DLY cycles
  logic [7:0] m_ac = 8'h00, m_e = 8'h00;
  logic       m_cy = 1'b0, m_ov = 1'b0, m_ie = 1'b0, m_done = 1'b0;
  logic [2:0] m_f = 3'd0;
  int         m_left = 0;

  task automatic model_reset();
    m_ac = 8'h00; m_e = 8'h00; m_cy = 1'b0; m_ov = 1'b0; m_ie = 1'b0;
    m_f = 3'd0; m_done = 1'b0; m_left = 0;
  endtask

  task automatic model_edge();
    logic [7:0] oac, oe;
    oac = m_ac;
    oe  = m_e;
    m_done = 1'b0;
    if (!rst_n || !ce) return;
    if (m_left > 0) begin
      if (ie_clr) m_ie = 1'b0; else if (ie_set) m_ie = 1'b1;
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_ac = 8'hFF;
        m_done = 1'b1;
      end
      return;
    end
    if (xae) begin
      m_ac = oe;
      m_e  = oac;
    end else begin
      if (ac_we) m_ac = alu_res;
      if (e_we) m_e = alu_res; else if (sio_en) m_e = {sin, oe[7:1]};
    end
    if (flag_we) begin m_cy = alu_cy; m_ov = alu_ov; end
    else if (sr_we) begin m_cy = oac[7]; m_ov = oac[6]; end
    if (ie_clr) m_ie = 1'b0; else if (ie_set) m_ie = 1'b1; else if (sr_we) m_ie = oac[3];
    if (sr_we) m_f = oac[2:0];
    if (dly_start) m_left = 13 + 2 * int'(oac) + 2 * int'(dly_disp) + 512 * int'(dly_disp);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic [9:0] s, input logic [3:0] fl, input logic [7:0] res);
    {ce, ac_we, e_we, flag_we, xae, sr_we, ie_set, ie_clr, sio_en, sin} = s;
    {alu_cy, alu_ov, sense_b, sense_a} = fl;
    alu_res = res;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  localparam logic [9:0] CE = 10'h200, AW = 10'h100, EW = 10'h080, FW = 10'h040;
  localparam logic [9:0] XA = 10'h020, SW = 10'h010, IS = 10'h008, IC = 10'h004;
  localparam logic [9:0] SI = 10'h002, SN = 10'h001;

  typedef struct packed {
    logic [9:0] str;
    logic [3:0] flg;   // {alu_cy, alu_ov, sense_b, sense_a}
    logic [7:0] res;
    logic [7:0] x_ac;
    logic [7:0] x_e;
    logic [7:0] x_sr;
  } vec_t;

  vec_t vec [15];

  // Runs one DLY and counts ce-qualified busy edges up to the done pulse
  task automatic run_dly(input logic [7:0] disp, input int exp_n, input bit gaps);
    int  n;
    bit  seen;
    drive(CE, 4'b0000, 8'h00);
    dly_start = 1'b1;
    dly_disp  = disp;
    step();
    dly_start = 1'b0;
    n = 0;
    seen = 1'b0;
    for (int k = 0; k < 5000 && !seen; k++) begin
      ce = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (gaps) begin
        ac_we = 1'b1; xae = 1'b1; alu_res = 8'h55;
      end
      if (dly_busy && ce) n++;
      step();
      if (dly_done) seen = 1'b1;
    end
    drive(10'h000, 4'b0000, 8'h00);
    chk("dly_done_seen", 32'(seen), 32'd1);
    chk("dly_busy_len", n, exp_n);
    chk("dly_ac_ff", 32'(ac_o), 32'hFF);
    chk("dly_busy_end", 32'(dly_busy), 32'd0);
    step();
    chk("dly_done_pulse", 32'(dly_done), 32'd0);
  endtask

  initial begin
    vec[0]  = '{CE|AW|FW,       4'b1000, 8'h5A, 8'h5A, 8'h00, 8'h80};
    vec[1]  = '{AW|FW,          4'b0100, 8'h77, 8'h5A, 8'h00, 8'h80};
    vec[2]  = '{CE|AW,          4'b0000, 8'h12, 8'h12, 8'h00, 8'h80};
    vec[3]  = '{CE|EW,          4'b0000, 8'h34, 8'h12, 8'h34, 8'h80};
    vec[4]  = '{CE|XA|AW,       4'b0000, 8'h99, 8'h34, 8'h12, 8'h80};
    vec[5]  = '{CE|AW,          4'b0000, 8'hFF, 8'hFF, 8'h12, 8'h80};
    vec[6]  = '{CE|SW,          4'b0000, 8'h00, 8'hFF, 8'h12, 8'hCF};
    vec[7]  = '{CE|SW|FW,       4'b0100, 8'h00, 8'hFF, 8'h12, 8'h4F};
    vec[8]  = '{CE|IS|IC,       4'b0000, 8'h00, 8'hFF, 8'h12, 8'h47};
    vec[9]  = '{CE|AW,          4'b0000, 8'h00, 8'h00, 8'h12, 8'h47};
    vec[10] = '{CE|IS|SW,       4'b0000, 8'h00, 8'h00, 8'h12, 8'h08};
    vec[11] = '{10'h000,        4'b0011, 8'h00, 8'h00, 8'h12, 8'h38};
    vec[12] = '{CE|EW|SI|SN,    4'b0000, 8'hA5, 8'h00, 8'hA5, 8'h08};
    vec[13] = '{CE|SI,          4'b0000, 8'h00, 8'h00, 8'h52, 8'h08};
    vec[14] = '{CE|XA|EW|SI,    4'b0000, 8'h11, 8'h52, 8'h00, 8'h08};

    // Reset with sense_a high
    sense_a = 1'b1;
    #3;
    chk("rst_ac", 32'(ac_o), 32'h00);
    chk("rst_e", 32'(e_o), 32'h00);
    chk("rst_sr", 32'(sr_o), 32'h10);
    chk("rst_busy", 32'(dly_busy), 32'd0);
    chk("rst_sout", 32'(sout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sense_a = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drive(vec[i].str, vec[i].flg, vec[i].res);
      step();
      chk($sformatf("vec%0d_ac", i), 32'(ac_o), 32'(vec[i].x_ac));
      chk($sformatf("vec%0d_e", i), 32'(e_o), 32'(vec[i].x_e));
      chk($sformatf("vec%0d_sr", i), 32'(sr_o), 32'(vec[i].x_sr));
    end
    drive(10'h000, 4'b0000, 8'h00);

    // Serial shift: eight ones into a cleared E
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      drive(CE|SI|SN, 4'b0000, 8'h00);
      step();
      chk($sformatf("sio_sout%0d", k), 32'(sout), (k == 8) ? 32'd1 : 32'd0);
    end
    chk("sio_e", 32'(e_o), 32'hFF);
    drive(10'h000, 4'b0000, 8'h00);

    // DLY lengths
    do_reset();
    run_dly(8'h00, 13, 1'b0);
    drive(CE|AW, 4'b0000, 8'h02);
    step();
    run_dly(8'h01, 531, 1'b1);

    // DLY aborted by reset
    drive(CE|AW, 4'b0000, 8'h02);
    step();
    drive(CE, 4'b0000, 8'h00);
    dly_start = 1'b1;
    dly_disp  = 8'h01;
    step();
    dly_start = 1'b0;
    for (int k = 0; k < 100; k++) step();
    chk("abort_busy_before", 32'(dly_busy), 32'd1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("abort_busy", 32'(dly_busy), 32'd0);
    chk("abort_ac", 32'(ac_o), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 600; k++) begin
        step();
        if (dly_done || dly_busy) seen = 1'b1;
      end
      chk("abort_no_done", 32'(seen), 32'd0);
      chk("abort_ac_hold", 32'(ac_o), 32'h00);
    end

    // Randomised run against the model
    drive(10'h000, 4'b0000, 8'h00);
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      ce      = ($urandom_range(0, 3) != 0);
      ac_we   = ($urandom_range(0, 3) == 0);
      e_we    = ($urandom_range(0, 3) == 0);
      flag_we = ($urandom_range(0, 3) == 0);
      xae     = ($urandom_range(0, 5) == 0);
      sr_we   = ($urandom_range(0, 4) == 0);
      ie_set  = ($urandom_range(0, 4) == 0);
      ie_clr  = ($urandom_range(0, 4) == 0);
      sio_en  = ($urandom_range(0, 3) == 0);
      sin     = 1'($urandom);
      alu_res = 8'($urandom);
      alu_cy  = 1'($urandom);
      alu_ov  = 1'($urandom);
      sense_a = 1'($urandom);
      sense_b = 1'($urandom);
      dly_start = ($urandom_range(0, 39) == 0);
      dly_disp  = 8'($urandom_range(0, 2));
      step();
      chk("rnd_ac", 32'(ac_o), 32'(m_ac));
      chk("rnd_e", 32'(e_o), 32'(m_e));
      chk("rnd_sr", 32'(sr_o), 32'({m_cy, m_ov, sense_b, sense_a, m_ie, m_f}));
      chk("rnd_sout", 32'(sout), 32'(m_e[0]));
      chk("rnd_busy", 32'(dly_busy), 32'(m_left > 0));
      chk("rnd_done", 32'(dly_done), 32'(m_done));
      chk("rnd_cyovf", 32'({cy_o, ov_o, f_o}), 32'({m_cy, m_ov, m_f}));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
